// File: rtl/conv_sched_if.sv
// conv_sched_if: handshake/bus bundle between the window scheduler and its
// neighbours (feature-map SRAM, PE row loader, output memory).
//   master : scheduler side (drives busy/done/err, pixel reads, row beats,
//            output writes; receives start/wt_cfg/pixel data/mac result)
//   slave  : environment side (the mirror image)
interface conv_sched_if #(
   parameter int ADDR_W  = 6,
   parameter int OADDR_W = 6,
   parameter int MAC_W   = 20
);
   logic               start;
   logic [71:0]        wt_cfg;
   logic               busy;
   logic               done;
   logic               err;
   logic               fm_rd_en;
   logic [ADDR_W-1:0]  fm_rd_addr;
   logic [7:0]         fm_rd_data;
   logic               pe_clr;
   logic               send;
   logic [23:0]        row_data;
   logic [23:0]        row_wt;
   logic               mac_valid;
   logic [MAC_W-1:0]   mac_sum;
   logic               out_wr_en;
   logic [OADDR_W-1:0] out_wr_addr;
   logic [MAC_W-1:0]   out_wr_data;

   modport master (
      input  start, wt_cfg, fm_rd_data, mac_valid, mac_sum,
      output busy, done, err, fm_rd_en, fm_rd_addr, pe_clr, send,
             row_data, row_wt, out_wr_en, out_wr_addr, out_wr_data
   );

   modport slave (
      output start, wt_cfg, fm_rd_data, mac_valid, mac_sum,
      input  busy, done, err, fm_rd_en, fm_rd_addr, pe_clr, send,
             row_data, row_wt, out_wr_en, out_wr_addr, out_wr_data
   );
endinterface

// File: rtl/conv_sched.sv
// conv_sched: 3x3 window scheduler for the convolution PE array.
// On start it walks every 3x3 window of an IMG_W x IMG_H map in raster
// order: clear the row loader, fetch 9 pixels, send 4 row beats, wait for
// the PE result (or time out), write it to the output memory.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - conv_sched_if.master (start/wt_cfg/busy/done/err, pixel read
//          port, row-beat loader port, mac result, output write port)
// All bus outputs come straight from registers.
module conv_sched #(
   parameter int IMG_W    = 8,
   parameter int IMG_H    = 8,
   parameter int ADDR_W   = 6,
   parameter int OADDR_W  = 6,
   parameter int MAC_W    = 20,
   parameter int WAIT_MAX = 32
) (
   input  logic          clk,
   input  logic          rst,
   conv_sched_if.master  bus
);
   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);
   localparam int WW = $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_FETCH, S_SEND, S_WAIT, S_WRITE, S_DONE
   } state_t;

   state_t             state_q;
   logic [RW-1:0]      row_q;
   logic [CW-1:0]      col_q;
   logic [3:0]         cnt_q;         // fetch cycle 0..9 / send beat 0..3
   logic [1:0]         fi_q, fj_q;    // window offset of the current read
   logic [WW-1:0]      wcnt_q;
   logic [71:0]        wt_q;
   // Slots 0..7 of the window; the ninth pixel arrives in the same cycle
   // beat 0 is launched, so it goes straight into row_data.
   logic [7:0][7:0]    pix_q;

   logic               busy_q, done_q, err_q, rd_en_q, clr_q, send_q, wr_en_q;
   logic [ADDR_W-1:0]  rd_addr_q;
   logic [23:0]        rdata_q, rwt_q;
   logic [OADDR_W-1:0] wr_addr_q;
   logic [MAC_W-1:0]   wr_data_q;

   // Next read position and addresses derived from the window counters.
   logic [1:0]         fi_d, fj_d;
   logic [ADDR_W-1:0]  rd_addr_d, win_addr_d;
   logic [OADDR_W-1:0] wr_addr_d;
   logic               last_win;

   always_comb begin
      fj_d       = (fj_q == 2'd2) ? 2'd0 : fj_q + 2'd1;
      fi_d       = (fj_q == 2'd2) ? fi_q + 2'd1 : fi_q;
      rd_addr_d  = ADDR_W'((int'(row_q) + int'(fi_d)) * IMG_W + int'(col_q) + int'(fj_d));
      win_addr_d = ADDR_W'(int'(row_q) * IMG_W + int'(col_q));
      wr_addr_d  = OADDR_W'(int'(row_q) * (IMG_W - 2) + int'(col_q));
      last_win   = (row_q == RW'(IMG_H - 3)) && (col_q == CW'(IMG_W - 3));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         row_q     <= '0;
         col_q     <= '0;
         cnt_q     <= '0;
         fi_q      <= '0;
         fj_q      <= '0;
         wcnt_q    <= '0;
         wt_q      <= '0;
         pix_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         clr_q     <= 1'b0;
         send_q    <= 1'b0;
         rdata_q   <= '0;
         rwt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.start) begin
               wt_q    <= bus.wt_cfg;
               err_q   <= 1'b0;
               busy_q  <= 1'b1;
               row_q   <= '0;
               col_q   <= '0;
               clr_q   <= 1'b1;
               state_q <= S_CLR;
            end
            S_CLR: begin
               clr_q     <= 1'b0;
               rd_en_q   <= 1'b1;
               rd_addr_q <= win_addr_d;
               fi_q      <= '0;
               fj_q      <= '0;
               cnt_q     <= '0;
               state_q   <= S_FETCH;
            end
            S_FETCH: begin
               // Data for the read issued in cycle k lands in cycle k+1.
               if (cnt_q != 4'd0 && cnt_q != 4'd9)
                  pix_q[cnt_q[2:0] - 3'd1] <= bus.fm_rd_data;
               if (cnt_q < 4'd8) begin
                  rd_addr_q <= rd_addr_d;
                  fi_q      <= fi_d;
                  fj_q      <= fj_d;
               end else begin
                  rd_en_q <= 1'b0;
               end
               if (cnt_q == 4'd9) begin
                  cnt_q   <= '0;
                  send_q  <= 1'b1;
                  rdata_q <= {pix_q[6], pix_q[7], bus.fm_rd_data};
                  rwt_q   <= wt_q[23:0];
                  state_q <= S_SEND;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_SEND: begin
               cnt_q <= cnt_q + 4'd1;
               case (cnt_q[1:0])
                  2'd0: begin
                     rdata_q <= {pix_q[3], pix_q[4], pix_q[5]};
                     rwt_q   <= wt_q[47:24];
                  end
                  2'd1: begin
                     rdata_q <= {pix_q[0], pix_q[1], pix_q[2]};
                     rwt_q   <= wt_q[71:48];
                  end
                  2'd2: begin
                     rdata_q <= '0;
                     rwt_q   <= '0;
                  end
                  default: begin
                     send_q  <= 1'b0;
                     wcnt_q  <= '0;
                     state_q <= S_WAIT;
                  end
               endcase
            end
            S_WAIT: begin
               // A result on the expiry cycle still counts as on time.
               if (bus.mac_valid) begin
                  wr_data_q <= bus.mac_sum;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= wr_addr_d;
                  state_q   <= S_WRITE;
               end else if (wcnt_q == WW'(WAIT_MAX - 1)) begin
                  err_q     <= 1'b1;
                  wr_data_q <= '0;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= wr_addr_d;
                  state_q   <= S_WRITE;
               end else begin
                  wcnt_q <= wcnt_q + WW'(1);
               end
            end
            S_WRITE: begin
               wr_en_q <= 1'b0;
               if (col_q == CW'(IMG_W - 3)) begin
                  col_q <= '0;
                  row_q <= row_q + RW'(1);
               end else begin
                  col_q <= col_q + CW'(1);
               end
               if (last_win) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  clr_q   <= 1'b1;
                  state_q <= S_CLR;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.fm_rd_en    = rd_en_q;
   assign bus.fm_rd_addr  = rd_addr_q;
   assign bus.pe_clr      = clr_q;
   assign bus.send        = send_q;
   assign bus.row_data    = rdata_q;
   assign bus.row_wt      = rwt_q;
   assign bus.out_wr_en   = wr_en_q;
   assign bus.out_wr_addr = wr_addr_q;
   assign bus.out_wr_data = wr_data_q;
endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched on a 4x4 map (p[a]=a): beat contents,
// sums, timeout, ignored start/mac_valid, mid-run reset, expiry race.
module tb_conv_sched;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   conv_sched_if #(.ADDR_W(6), .OADDR_W(6), .MAC_W(20)) bus();

   conv_sched #(.IMG_W(4), .IMG_H(4), .ADDR_W(6), .OADDR_W(6),
                .MAC_W(20), .WAIT_MAX(32))
      dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int failures = 0;

   // ---------------- pixel memory: data one cycle after read ----------
   logic [7:0] mem [0:63];
   always @(posedge clk) if (bus.fm_rd_en) bus.fm_rd_data <= mem[bus.fm_rd_addr];

   // ---------------- PE responder --------------------------------------
   bit pe_en = 1'b1;
   bit spur_en = 1'b0;
   int pe_n = 3;
   logic [19:0] acc;
   int beat, dly;
   logic pe_valid, spur_valid;

   function automatic logic [19:0] dot(input logic [23:0] d, input logic [23:0] w);
      logic [19:0] s = '0;
      for (int k = 0; k < 3; k++) s += 20'(d[8*k +: 8]) * 20'(w[8*k +: 8]);
      return s;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0; beat <= 0; dly <= 0; pe_valid <= 1'b0; spur_valid <= 1'b0;
      end else begin
         pe_valid   <= 1'b0;
         spur_valid <= 1'b0;
         if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) pe_valid <= 1'b1;
         end
         if (bus.pe_clr) begin
            acc <= '0; beat <= 0;
         end else if (bus.send) begin
            acc  <= acc + dot(bus.row_data, bus.row_wt);
            beat <= beat + 1;
            if (beat == 3 && pe_en) begin
               if (pe_n == 1) pe_valid <= 1'b1;
               else dly <= pe_n - 1;
            end
            if (beat == 1 && spur_en) spur_valid <= 1'b1;
         end
      end
   end
   assign bus.mac_valid = pe_valid | spur_valid;
   assign bus.mac_sum   = spur_valid ? 20'hFFFFF : acc;

   // ---------------- monitor ------------------------------------------
   int cyc = 0, wr_cnt = 0, beat_cnt = 0, done_cnt = 0, done_busy_bad = 0;
   int last_clr = 0, gap_bad = 0, ovl_bad = 0;
   bit send_prev = 1'b0;
   logic [5:0]  wa_log [0:63];
   logic [19:0] wd_log [0:63];
   logic [23:0] bd_log [0:255];
   logic [23:0] bw_log [0:255];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.out_wr_en && wr_cnt < 64) begin
         wa_log[wr_cnt] = bus.out_wr_addr;
         wd_log[wr_cnt] = bus.out_wr_data;
         wr_cnt = wr_cnt + 1;
      end
      if (bus.done) begin
         done_cnt = done_cnt + 1;
         if (bus.busy) done_busy_bad = done_busy_bad + 1;
      end
      if (bus.pe_clr) last_clr = cyc;
      if (bus.send) begin
         if (beat_cnt < 256) begin
            bd_log[beat_cnt] = bus.row_data;
            bw_log[beat_cnt] = bus.row_wt;
            beat_cnt = beat_cnt + 1;
         end
         if (!send_prev && (cyc - last_clr) != 11) gap_bad = gap_bad + 1;
         if (bus.pe_clr || bus.fm_rd_en || bus.out_wr_en) ovl_bad = ovl_bad + 1;
      end
      send_prev = bus.send;
   end

   // ---------------- helpers ------------------------------------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      return 128'({bus.busy, bus.done, bus.err, bus.fm_rd_en, bus.fm_rd_addr,
                   bus.pe_clr, bus.send, bus.row_data, bus.row_wt,
                   bus.out_wr_en, bus.out_wr_addr, bus.out_wr_data});
   endfunction

   task automatic pulse_start();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int d0 = done_cnt;
      int k = 0;
      while (done_cnt == d0 && k < 3000) begin @(negedge clk); k++; end
      chk(tag, 128'(done_cnt - d0), 128'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_run(input string tag, input int base,
                            input logic [19:0] e0, e1, e2, e3);
      logic [19:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      chk({tag, "_nwr"}, 128'(wr_cnt - base), 128'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_addr%0d", tag, k), 128'(wa_log[base+k]), 128'(k));
         chk($sformatf("%s_data%0d", tag, k), 128'(wd_log[base+k]), 128'(e[k]));
      end
   endtask

   // ---------------- directed sequence --------------------------------
   initial begin
      int wb, bb, d0, k;
      for (int a = 0; a < 64; a++) mem[a] = (a < 16) ? 8'(a) : 8'h00;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.wt_cfg = '0;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", outs(), 128'd0);
      @(negedge clk) rst = 1'b0;

      // Run A: mixed kernel, first-window timing and beats.
      bus.wt_cfg = 72'h010203_040506_070809;
      wb = wr_cnt; bb = beat_cnt;
      pulse_start();
      @(negedge clk);
      chk("a_clr_cycle", {bus.pe_clr, bus.fm_rd_en, bus.busy}, 3'b101);
      @(negedge clk);
      chk("a_first_rd", {bus.fm_rd_en, bus.fm_rd_addr}, {1'b1, 6'd0});
      wait_done("a_done");
      chk("a_beat0_data", bd_log[bb+0], 24'h08090A);
      chk("a_beat0_wt",   bw_log[bb+0], 24'h070809);
      chk("a_beat1_data", bd_log[bb+1], 24'h040506);
      chk("a_beat1_wt",   bw_log[bb+1], 24'h040506);
      chk("a_beat2_data", bd_log[bb+2], 24'h000102);
      chk("a_beat2_wt",   bw_log[bb+2], 24'h010203);
      chk("a_beat3_data", bd_log[bb+3], 24'h000000);
      chk("a_beat3_wt",   bw_log[bb+3], 24'h000000);
      chk("a_win0_sum",   wd_log[wb], 20'd303);

      // Run B: all-ones kernel, clean sums.
      bus.wt_cfg = 72'h010101_010101_010101;
      wb = wr_cnt; d0 = done_cnt;
      pulse_start();
      wait_done("b_done");
      check_run("b", wb, 20'd45, 20'd54, 20'd81, 20'd90);
      chk("b_done_once", 128'(done_cnt - d0), 128'd1);
      chk("b_busy_with_done", 128'(done_busy_bad), 128'd0);
      chk("b_err", bus.err, 1'b0);
      chk("b_idle_busy", bus.busy, 1'b0);

      // Run C: no result ever, every window times out.
      pe_en = 1'b0;
      wb = wr_cnt;
      pulse_start();
      wait_done("c_done");
      check_run("c", wb, 20'd0, 20'd0, 20'd0, 20'd0);
      chk("c_err_set", bus.err, 1'b1);
      pe_en = 1'b1;

      // Run D: start clears err; stray start and mac_valid are ignored.
      spur_en = 1'b1;
      wb = wr_cnt; d0 = done_cnt;
      pulse_start();
      chk("d_err_cleared", bus.err, 1'b0);
      k = 0;
      while (!bus.fm_rd_en && k < 50) begin @(negedge clk); k++; end
      chk("d_reach_fetch", bus.fm_rd_en, 1'b1);
      pulse_start();
      k = 0;
      while (!bus.send && k < 50) begin @(negedge clk); k++; end
      while (bus.send && k < 50) begin @(negedge clk); k++; end
      chk("d_reach_wait", {bus.send, bus.out_wr_en}, 2'b00);
      pulse_start();
      wait_done("d_done");
      check_run("d", wb, 20'd45, 20'd54, 20'd81, 20'd90);
      chk("d_done_once", 128'(done_cnt - d0), 128'd1);
      spur_en = 1'b0;

      // Run E: reset while window 2 is sending, then a fresh full run.
      wb = wr_cnt; d0 = done_cnt;
      pulse_start();
      k = 0;
      while (!((wr_cnt - wb) == 1 && bus.send) && k < 200) begin @(negedge clk); k++; end
      chk("e_reach_send2", bus.send, 1'b1);
      rst = 1'b1;
      #1 chk("e_abort_outputs", outs(), 128'd0);
      repeat (3) @(negedge clk);
      chk("e_no_partial_write", 128'(wr_cnt - wb), 128'd1);
      chk("e_no_done", 128'(done_cnt - d0), 128'd0);
      rst = 1'b0;
      wb = wr_cnt;
      pulse_start();
      wait_done("e_done");
      check_run("e", wb, 20'd45, 20'd54, 20'd81, 20'd90);

      // Run F: result arrives on the expiry cycle.
      pe_n = 32;
      wb = wr_cnt;
      pulse_start();
      wait_done("f_done");
      check_run("f", wb, 20'd45, 20'd54, 20'd81, 20'd90);
      chk("f_err_clear", bus.err, 1'b0);

      chk("clr_to_send_gap", 128'(gap_bad), 128'd0);
      chk("send_overlap", 128'(ovl_bad), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
